wb_sdram_arbiter: RTL and testbench

- Round-robin Wishbone B3 arbiter that shares the single slave port of memory_controller between NUM_MASTERS requesters. Sits in the sys_clk domain, between the requesters and memory_controller.
- Holds a grant for a complete Wishbone cycle, including incrementing bursts (cti 3'b010 terminated by 3'b111).
- Blocks all grants until SDRAM initialisation completes.
- Aborts a hung cycle with err after a programmable number of cycles without an ack.

---
 rtl/wb_sdram_arbiter_pkg.sv | 14 +
 rtl/wb_sdram_arbiter_rr_picker.sv | 26 ++
 rtl/wb_sdram_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sdram_arbiter_pkg.sv
// Shared types and constants for the Wishbone SDRAM arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_sdram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int PW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic                   valid
);

  always_comb begin
    int idx;
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(ptr) + i) % NUM_MASTERS;
      if (!valid && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone arbiter in front of the single memory_controller slave port,
// holding the grant for a full cycle and aborting hung cycles via a watchdog.
module wb_sdram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int dw          = 32,
  parameter int APP_AW      = 26,
  parameter int TIMEOUT_W   = 10
) (
  input  logic                            sys_clk,
  input  logic                            sys_resetn,
  input  logic                            sdr_init_done,
  input  logic [TIMEOUT_W-1:0]            cfg_timeout,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*APP_AW-1:0]   m_addr_i,
  input  logic [NUM_MASTERS*dw-1:0]       m_dat_i,
  input  logic [NUM_MASTERS*(dw/8)-1:0]   m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]        m_cti_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [dw-1:0]                   m_dat_o,
  output logic                            wb_cyc_o,
  output logic                            wb_stb_o,
  output logic                            wb_we_o,
  output logic [APP_AW-1:0]               wb_addr_o,
  output logic [dw-1:0]                   wb_dat_o,
  output logic [dw/8-1:0]                 wb_sel_o,
  output logic [2:0]                      wb_cti_o,
  input  logic                            wb_ack_i,
  input  logic [dw-1:0]                   wb_dat_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  output logic                            timeout_o
);

  localparam int PW = $clog2(NUM_MASTERS);
  localparam int SW = dw / 8;

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_q, grant_nxt, pick_gnt;
  logic                   pick_vld;
  logic [PW-1:0]          rr_ptr, rr_ptr_nxt, owner;
  logic [TIMEOUT_W-1:0]   wdog, wdog_nxt, wdog_inc;
  logic                   own_cyc, own_stb, own_we;
  logic [APP_AW-1:0]      own_addr;
  logic [dw-1:0]          own_dat;
  logic [SW-1:0]          own_sel;
  logic [2:0]             own_cti;
  logic                   fire;

  rr_picker #(.NUM_MASTERS(NUM_MASTERS), .PW(PW)) u_pick (
    .req   (m_cyc_i),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  // grant_q is zero outside GRANT, so the mux yields all-zero bus signals when idle
  always_comb begin
    owner    = '0;
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_dat  = '0;
    own_sel  = '0;
    own_cti  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        owner    = PW'(k);
        own_cyc  = m_cyc_i[k];
        own_stb  = m_stb_i[k];
        own_we   = m_we_i[k];
        own_addr = m_addr_i[k*APP_AW +: APP_AW];
        own_dat  = m_dat_i[k*dw +: dw];
        own_sel  = m_sel_i[k*SW +: SW];
        own_cti  = m_cti_i[k*3 +: 3];
      end
    end
  end

  // Counter value including the current strobe cycle; saturates instead of wrapping.
  assign wdog_inc = (&wdog) ? wdog : wdog + 1'b1;
  assign fire     = (state == GRANT) && own_cyc && own_stb && !wb_ack_i &&
                    (cfg_timeout != '0) && (wdog_inc == cfg_timeout);

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    rr_ptr_nxt = rr_ptr;
    wdog_nxt   = wdog;
    case (state)
      IDLE: begin
        if (sdr_init_done && pick_vld) begin
          state_nxt = GRANT;
          grant_nxt = pick_gnt;
          wdog_nxt  = '0;
        end
      end
      GRANT: begin
        if (wb_ack_i)     wdog_nxt = '0;
        else if (own_stb) wdog_nxt = wdog_inc;
        if (!own_cyc || fire) begin
          state_nxt  = RELEASE;
          grant_nxt  = '0;
          wdog_nxt   = '0;
          rr_ptr_nxt = (owner == PW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
      wdog    <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      rr_ptr  <= rr_ptr_nxt;
      wdog    <= wdog_nxt;
    end
  end

  assign wb_cyc_o  = own_cyc & ~fire;
  assign wb_stb_o  = own_stb & ~fire;
  assign wb_we_o   = own_we;
  assign wb_addr_o = own_addr;
  assign wb_dat_o  = own_dat;
  assign wb_sel_o  = own_sel;
  assign wb_cti_o  = own_cti;

  assign m_ack_o   = grant_q & {NUM_MASTERS{wb_ack_i}};
  assign m_err_o   = grant_q & {NUM_MASTERS{fire}};
  assign m_dat_o   = wb_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = fire;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed + randomized bench for wb_sdram_arbiter with a round-robin reference model.
module tb_wb_sdram_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 26;
  localparam int TW = 10;

  logic              sys_clk = 1'b0;
  logic              sys_resetn, sdr_init_done;
  logic [TW-1:0]     cfg_timeout;
  logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0]   m_addr_i;
  logic [N*DW-1:0]   m_dat_i;
  logic [N*DW/8-1:0] m_sel_i;
  logic [N*3-1:0]    m_cti_i;
  logic [N-1:0]      m_ack_o, m_err_o, grant_o;
  logic [DW-1:0]     m_dat_o, wb_dat_o, wb_dat_i;
  logic              wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, timeout_o;
  logic [AW-1:0]     wb_addr_o;
  logic [DW/8-1:0]   wb_sel_o;
  logic [2:0]        wb_cti_o;

  logic [N-1:0]      cyc, stb, we;
  logic [AW-1:0]     addr [N];
  logic [DW-1:0]     dat  [N];
  logic [DW/8-1:0]   sel  [N];
  logic [2:0]        cti  [N];

  int n_assert = 0;
  int n_fail   = 0;
  int ptr_m    = 0;

  always #5 sys_clk = ~sys_clk;

  assign m_cyc_i = cyc;
  assign m_stb_i = stb;
  assign m_we_i  = we;
  for (genvar k = 0; k < N; k++) begin : g_pack
    assign m_addr_i[k*AW +: AW]     = addr[k];
    assign m_dat_i[k*DW +: DW]      = dat[k];
    assign m_sel_i[k*DW/8 +: DW/8]  = sel[k];
    assign m_cti_i[k*3 +: 3]        = cti[k];
  end

  wb_sdram_arbiter #(.NUM_MASTERS(N), .dw(DW), .APP_AW(AW), .TIMEOUT_W(TW)) dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn), .sdr_init_done(sdr_init_done),
    .cfg_timeout(cfg_timeout), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int e);
    logic [N-1:0] one;
    one = 1;
    return one << e;
  endfunction

  // Reference rule: first requester found searching upward from the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++)
      if (m[2'((p + i) % N)]) return (p + i) % N;
    return -1;
  endfunction

  task automatic rand_master(input int k);
    addr[k] = AW'($urandom());
    dat[k]  = $urandom();
    sel[k]  = 4'($urandom_range(1, 15));
    we[k]   = 1'($urandom_range(0, 1));
  endtask

  // Owner drops cyc, then one RELEASE cycle and one IDLE cycle with the bus quiet.
  task automatic finish_round(input int e);
    tick();
    stb[e] = 1'b0; cyc[e] = 1'b0; wb_ack_i = 1'b0; cti[e] = CTI_CLASSIC;
    #1;
    chk("drop_wb_cyc", wb_cyc_o, 0);
    chk("drop_m_ack", m_ack_o, 0);
    ptr_m = (e + 1) % N;
    tick(); #1;
    chk("release_grant", grant_o, 0);
    chk("release_wb_cyc", wb_cyc_o, 0);
    tick(); #1;
    chk("idle_grant", grant_o, 0);
  endtask

  // Called in the first GRANT cycle; runs beats with wait states, then releases.
  task automatic do_round(input int e, input int beats, input int waits, input logic [N-1:0] extra);
    logic [N-1:0] g;
    g   = oh(e);
    cyc = cyc | extra;
    for (int b = 0; b < beats; b++) begin
      for (int w = 0; w <= waits; w++) begin
        if (b != 0 || w != 0) tick();
        cti[e]   = (beats == 1) ? CTI_CLASSIC : (b == beats - 1) ? CTI_EOB : CTI_INCR;
        stb[e]   = (w == waits) ? 1'b1 : 1'($urandom_range(0, 1));
        wb_ack_i = (w == waits);
        wb_dat_i = $urandom();
        #1;
        chk("grant", grant_o, g);
        chk("wb_cyc", wb_cyc_o, 1);
        chk("wb_stb", wb_stb_o, stb[e]);
        chk("m_ack", m_ack_o, wb_ack_i ? g : '0);
        chk("m_err", m_err_o, 0);
        if (w == waits) begin
          chk("wb_addr", wb_addr_o, addr[e]);
          chk("wb_we", wb_we_o, we[e]);
          chk("wb_dat", wb_dat_o, dat[e]);
          chk("wb_sel", wb_sel_o, sel[e]);
          chk("wb_cti", wb_cti_o, cti[e]);
          chk("m_dat", m_dat_o, wb_dat_i);
        end
      end
    end
    finish_round(e);
  endtask

  task automatic serve_next(input int beats, input int waits);
    tick();
    do_round(rr_pick(cyc, ptr_m), beats, waits, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset dominates even with requests and ack present.
    sys_resetn = 1'b0; sdr_init_done = 1'b1; cfg_timeout = '0;
    cyc = '1; stb = '1; we = '0; wb_ack_i = 1'b1; wb_dat_i = '0;
    for (int k = 0; k < N; k++) begin rand_master(k); cti[k] = CTI_CLASSIC; end
    tick(); tick(); #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_wb_cyc", wb_cyc_o, 0);
    chk("rst_wb_stb", wb_stb_o, 0);
    chk("rst_wb_addr", wb_addr_o, 0);
    chk("rst_wb_dat", wb_dat_o, 0);
    chk("rst_m_ack", m_ack_o, 0);
    chk("rst_m_err", m_err_o, 0);
    chk("rst_timeout", timeout_o, 0);

    // 1: no grant until SDRAM init completes.
    sys_resetn = 1'b1; sdr_init_done = 1'b0; cyc = 4'b0001; stb = '0; wb_ack_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      chk("noinit_grant", grant_o, 0);
      chk("noinit_wb_cyc", wb_cyc_o, 0);
    end
    sdr_init_done = 1'b1;
    serve_next(1, 0);

    // 2: everyone requesting, single writes with 2 wait states, rotation.
    cyc = '1; we = '1;
    for (int r = 0; r < 5; r++) begin
      serve_next(1, 2);
      cyc = '1;
    end

    // Randomized rounds against the round-robin model.
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < N; k++) rand_master(k);
      cyc = cyc | 4'($urandom_range(0, 15));
      if (cyc == '0) cyc[2'($urandom_range(0, 3))] = 1'b1;
      serve_next($urandom_range(1, 4), $urandom_range(0, 2));
    end
    for (int r = 0; r < N && cyc != '0; r++) serve_next(1, 0);

    // 3: 8-beat incrementing burst by master 2 while master 0 waits.
    cyc = 4'b0100; rand_master(2);
    tick();
    do_round(2, 8, 1, 4'b0001);
    serve_next(1, 0);

    // 4: watchdog abort of master 1 after 16 ack-less strobe cycles.
    cfg_timeout = 10'd16; cyc = 4'b0010; rand_master(1);
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) tick();
      stb[1] = 1'b1; wb_ack_i = 1'b0;
      if (i == 3) cyc[2] = 1'b1;
      #1;
      chk("t4_grant", grant_o, 4'b0010);
      if (i < 16) begin
        chk("t4_wb_cyc", wb_cyc_o, 1);
        chk("t4_no_err", m_err_o, 0);
        chk("t4_no_timeout", timeout_o, 0);
      end else begin
        chk("t4_err", m_err_o, 4'b0010);
        chk("t4_timeout", timeout_o, 1);
        chk("t4_cyc_forced", wb_cyc_o, 0);
        chk("t4_stb_forced", wb_stb_o, 0);
      end
    end
    tick(); stb[1] = 1'b0; cyc[1] = 1'b0; #1;
    chk("t4_pulse_end", timeout_o, 0);
    chk("t4_err_end", m_err_o, 0);
    chk("t4_release", grant_o, 0);
    ptr_m = 2;
    tick(); #1;
    chk("t4_idle", grant_o, 0);
    cfg_timeout = '0;
    serve_next(1, 0);

    // 5: ack coinciding with the timeout count wins; then watchdog disabled.
    cfg_timeout = 10'd5; cyc = 4'b0001; rand_master(0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) tick();
      stb[0] = 1'b1; wb_ack_i = (i == 5 || i == 10);
      #1;
      chk("t5_grant", grant_o, 4'b0001);
      chk("t5_wb_cyc", wb_cyc_o, 1);
      chk("t5_m_ack", m_ack_o, wb_ack_i ? 4'b0001 : 4'b0000);
      chk("t5_no_err", m_err_o, 0);
      chk("t5_no_timeout", timeout_o, 0);
    end
    cfg_timeout = '0;
    for (int i = 0; i < 30; i++) begin
      tick(); wb_ack_i = 1'b0; #1;
      chk("t5_disabled", {timeout_o, m_err_o}, 0);
    end
    finish_round(0);

    // 6: reset during master 3's burst restarts rotation at master 0.
    cyc = 4'b1000; rand_master(3);
    tick();
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) tick();
      stb[3] = 1'b1; cti[3] = CTI_INCR; wb_ack_i = 1'b1;
      #1;
      chk("t6_grant", grant_o, 4'b1000);
      chk("t6_m_ack", m_ack_o, 4'b1000);
    end
    tick(); sys_resetn = 1'b0; cyc = 4'b1001;
    tick(); #1;
    chk("t6_rst_grant", grant_o, 0);
    chk("t6_rst_wb_cyc", wb_cyc_o, 0);
    chk("t6_rst_wb_stb", wb_stb_o, 0);
    chk("t6_rst_m_ack", m_ack_o, 0);
    chk("t6_rst_err", {timeout_o, m_err_o}, 0);
    sys_resetn = 1'b1; stb = '0; wb_ack_i = 1'b0; cti[3] = CTI_CLASSIC;
    ptr_m = 0;
    rand_master(0);
    serve_next(1, 0);
    serve_next(1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
